// File: rtl/tone_pkg.sv
// Shared constants for the tone decoder: note encoding, octave-0 period table
// (50 MHz clk, A = 440 Hz at index 9) and the search FSM state type.
package tone_pkg;

   localparam logic [3:0] NOTE_NONE = 4'hF;
   localparam int         NUM_NOTES = 12;

   localparam logic [19:0] NOTE_PERIOD [NUM_NOTES] = '{
      20'd191113, 20'd180388, 20'd170265, 20'd160705,
      20'd151685, 20'd143172, 20'd135139, 20'd127551,
      20'd120395, 20'd113636, 20'd107258, 20'd101238
   };

   typedef enum logic [1:0] {IDLE, SEARCH, CONFIRM} state_t;

endpackage

// File: rtl/tone_period_meter.sv
// Synchronizes tone_in, detects rising edges and measures the period in clk cycles.
// Define TONE_DECODER_GLITCH_FILTER_EN to insert a 3-tap majority filter after the synchronizer.
module tone_period_meter #(
   parameter int PW         = 20,
   parameter int TIMEOUT    = 2**20-1,
   parameter int MIN_PERIOD = 1024
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          tone_in,
   input  logic          i_take,
   output logic          o_pend_vld,
   output logic [PW-1:0] o_pend_p,
   output logic          o_silence
);

   localparam logic [PW-1:0] CNT_MAX = '1;
   localparam logic [PW-1:0] MIN_P   = PW'(MIN_PERIOD);
   localparam logic [PW-1:0] TO_M1   = PW'(TIMEOUT - 1);

   logic          r_sync1, r_sync2, r_prev, r_edge, r_first;
   logic [PW-1:0] r_cnt;
   logic          w_filt, w_accept, w_capture, w_silence;

`ifdef TONE_DECODER_GLITCH_FILTER_EN
   logic r_tap1, r_tap2, r_maj;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_tap1 <= 1'b0;
         r_tap2 <= 1'b0;
         r_maj  <= 1'b0;
      end else begin
         r_tap1 <= r_sync2;
         r_tap2 <= r_tap1;
         r_maj  <= (r_sync2 & r_tap1) | (r_sync2 & r_tap2) | (r_tap1 & r_tap2);
      end
   end

   assign w_filt = r_maj;
`else
   assign w_filt = r_sync2;
`endif

   // Short edges are dropped without touching the counter, so a glitch cannot split a period.
   assign w_accept  = r_edge && (r_cnt >= MIN_P);
   assign w_capture = w_accept && !r_first;
   assign w_silence = !w_accept && (r_cnt == TO_M1);
   assign o_silence = w_silence;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_prev     <= 1'b0;
         r_edge     <= 1'b0;
         r_cnt      <= '0;
         r_first    <= 1'b1;
         o_pend_vld <= 1'b0;
         o_pend_p   <= '0;
      end else begin
         r_sync1 <= tone_in;
         r_sync2 <= r_sync1;
         r_prev  <= w_filt;
         r_edge  <= w_filt & ~r_prev;

         if (w_accept) begin
            r_cnt   <= PW'(1);
            r_first <= 1'b0;
         end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_silence) r_first <= 1'b1;

         // Single pending slot: a newer capture overwrites an unconsumed one.
         if (w_silence) begin
            o_pend_vld <= 1'b0;
         end else if (w_capture) begin
            o_pend_vld <= 1'b1;
            o_pend_p   <= r_cnt;
         end else if (i_take) begin
            o_pend_vld <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/tone_decoder.sv
// Recovers {octave, note} from a square-wave tone by period search over the shared table.
// Optional glitch filter in tone_period_meter is enabled by TONE_DECODER_GLITCH_FILTER_EN.
module tone_decoder
   import tone_pkg::*;
#(
   parameter int PW         = 20,
   parameter int TIMEOUT    = 2**20-1,
   parameter int MIN_PERIOD = 1024,
   parameter int TOL_SHIFT  = 6,
   parameter int STABLE_N   = 3,
   parameter int OCT_MAX    = 7
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       tone_in,
   output logic [3:0] note,
   output logic [3:0] octave,
   output logic       valid,
   output logic       changed
);

   localparam int MCW = $clog2(STABLE_N + 1);

   state_t          r_state, w_state_nxt;
   logic [PW-1:0]   r_p;
   logic [3:0]      r_o, r_n;
   logic [3:0]      r_cand_note, r_cand_oct, r_hist_note, r_hist_oct;
   logic [3:0]      r_note, r_oct;
   logic            r_valid, r_changed;
   logic [MCW-1:0]  r_mcnt;

   logic            w_pend_vld, w_silence, w_take, w_hit, w_last, w_same;
   logic            w_pub, w_pub_valid, w_differs;
   logic [PW-1:0]   w_pend_p, w_ref, w_tol;
   logic signed [PW:0] w_diff;
   logic [PW:0]     w_abs;
   logic [MCW-1:0]  w_mcnt_nxt;

   tone_period_meter #(
      .PW         (PW),
      .TIMEOUT    (TIMEOUT),
      .MIN_PERIOD (MIN_PERIOD)
   ) u_meter (
      .clk        (clk),
      .rstn       (rstn),
      .tone_in    (tone_in),
      .i_take     (w_take),
      .o_pend_vld (w_pend_vld),
      .o_pend_p   (w_pend_p),
      .o_silence  (w_silence)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_pend_vld) w_state_nxt = SEARCH;
         SEARCH:  if (w_hit || w_last) w_state_nxt = CONFIRM;
         CONFIRM: w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_take      = (r_state == IDLE) && w_pend_vld;
      w_ref       = PW'(NOTE_PERIOD[r_n] >> r_o);
      w_tol       = w_ref >> TOL_SHIFT;
      w_diff      = $signed({1'b0, r_p}) - $signed({1'b0, w_ref});
      w_abs       = w_diff[PW] ? -w_diff : w_diff;
      w_hit       = (r_state == SEARCH) && (w_abs <= {1'b0, w_tol});
      w_last      = (r_o == 4'(OCT_MAX)) && (r_n == 4'(NUM_NOTES - 1));
      w_same      = (r_cand_note == r_hist_note) && (r_cand_oct == r_hist_oct);
      w_mcnt_nxt  = MCW'(1);
      if (w_same) w_mcnt_nxt = (r_mcnt == MCW'(STABLE_N)) ? r_mcnt : r_mcnt + 1'b1;
      w_pub       = (r_state == CONFIRM) && (w_mcnt_nxt == MCW'(STABLE_N));
      w_pub_valid = (r_cand_note != NOTE_NONE);
      w_differs   = {w_pub_valid, r_cand_oct, r_cand_note} != {r_valid, r_oct, r_note};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_p         <= '0;
         r_o         <= '0;
         r_n         <= '0;
         r_cand_note <= NOTE_NONE;
         r_cand_oct  <= '0;
         r_hist_note <= NOTE_NONE;
         r_hist_oct  <= '0;
         r_mcnt      <= '0;
         r_note      <= NOTE_NONE;
         r_oct       <= '0;
         r_valid     <= 1'b0;
         r_changed   <= 1'b0;
      end else begin
         r_changed <= 1'b0;
         case (r_state)
            IDLE: if (w_take) begin
               r_p <= w_pend_p;
               r_o <= '0;
               r_n <= '0;
            end
            SEARCH: begin
               if (w_hit) begin
                  r_cand_note <= r_n;
                  r_cand_oct  <= r_o;
               end else if (w_last) begin
                  r_cand_note <= NOTE_NONE;
                  r_cand_oct  <= '0;
               end else if (r_n == 4'(NUM_NOTES - 1)) begin
                  r_n <= '0;
                  r_o <= r_o + 1'b1;
               end else begin
                  r_n <= r_n + 1'b1;
               end
            end
            CONFIRM: begin
               r_mcnt      <= w_mcnt_nxt;
               r_hist_note <= r_cand_note;
               r_hist_oct  <= r_cand_oct;
               if (w_pub) begin
                  r_note    <= r_cand_note;
                  r_oct     <= r_cand_oct;
                  r_valid   <= w_pub_valid;
                  r_changed <= w_differs;
               end
            end
            default: ;
         endcase
         // Silence overrides any same-cycle publish.
         if (w_silence) begin
            r_hist_note <= NOTE_NONE;
            r_hist_oct  <= '0;
            r_mcnt      <= '0;
            if (r_valid || r_note != NOTE_NONE) begin
               r_note    <= NOTE_NONE;
               r_oct     <= '0;
               r_valid   <= 1'b0;
               r_changed <= 1'b1;
            end
         end
      end
   end

   assign note    = r_note;
   assign octave  = r_oct;
   assign valid   = r_valid;
   assign changed = r_changed;

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder using short high-octave periods and a reduced TIMEOUT.
module tb_tone_decoder;

   logic       clk = 1'b0;
   logic       rstn;
   logic       tone_in;
   logic [3:0] note, octave;
   logic       valid, changed;

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;
   int chg_cnt = 0;
   int lat;

   always #5 clk = ~clk;

   tone_decoder #(.TIMEOUT(4000)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .tone_in (tone_in),
      .note    (note),
      .octave  (octave),
      .valid   (valid),
      .changed (changed)
   );

   always @(negedge clk) if (changed === 1'b1) chg_cnt++;

   initial begin
      repeat (100000) @(posedge clk);
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [3:0] n, input logic [3:0] o,
                            input logic v, input int chg);
      check({tag, "_out"}, {note, octave, valid}, {n, o, v});
      check({tag, "_changed"}, chg_cnt, chg);
   endtask

   task automatic run_tone(input int t, input int n);
      for (int i = 0; i < n; i++) begin
         tone_in = 1'b1;
         repeat (t / 2) @(negedge clk);
         tone_in = 1'b0;
         repeat (t - t / 2) @(negedge clk);
      end
   endtask

   task automatic run_glitch(input int t, input int n, input int goff, input int gw);
      for (int i = 0; i < n; i++) begin
         tone_in = 1'b1;
         repeat (t / 2) @(negedge clk);
         tone_in = 1'b0;
         repeat (goff - t / 2) @(negedge clk);
         tone_in = 1'b1;
         repeat (gw) @(negedge clk);
         tone_in = 1'b0;
         repeat (t - goff - gw) @(negedge clk);
      end
   endtask

   initial begin
      rstn    = 1'b0;
      tone_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         repeat (3) @(negedge clk);
         tone_in = ~tone_in;
         check("reset_hold", {note, octave, valid, changed}, {4'hF, 4'h0, 1'b0, 1'b0});
      end
      tone_in = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      repeat (1200) @(negedge clk);
      check("after_release", {note, octave, valid, changed}, {4'hF, 4'h0, 1'b0, 1'b0});

      // First edge discarded, two captures: not yet stable.
      run_tone(1775, 3);
      check("pre_lock_valid", valid, 1'b0);
      tone_in = 1'b1;
      lat = 0;
      while (valid !== 1'b1 && lat < 120) begin
         @(negedge clk);
         lat++;
      end
      check("lock_latency_le_101", lat <= 101, 1);
      repeat (887 - lat) @(negedge clk);
      tone_in = 1'b0;
      repeat (888) @(negedge clk);
      check_out("lock_a_o6", 4'd9, 4'd6, 1'b1, 1);

      run_tone(1775, 1);
      check_out("relock_no_pulse", 4'd9, 4'd6, 1'b1, 1);

      run_tone(1791, 3);
      check_out("plus_0p9pct", 4'd9, 4'd6, 1'b1, 1);

      run_tone(1725, 4);
      check_out("off_pitch_none", 4'hF, 4'd0, 1'b0, 2);

      run_tone(1493, 4);
      check_out("c_oct7", 4'd0, 4'd7, 1'b1, 3);

      run_glitch(1493, 2, 950, 3);
      run_glitch(1493, 1, 1000, 1);
      check_out("glitch_ignored", 4'd0, 4'd7, 1'b1, 3);

      repeat (4000 - 1493 - 60) @(negedge clk);
      check("pre_timeout_valid", valid, 1'b1);
      repeat (120) @(negedge clk);
      check_out("silence", 4'hF, 4'd0, 1'b0, 4);

      run_tone(1775, 3);
      check("resume_pending", valid, 1'b0);
      run_tone(1775, 1);
      check_out("resume_lock", 4'd9, 4'd6, 1'b1, 5);

      // Reset while the next capture is being searched.
      tone_in = 1'b1;
      repeat (20) @(negedge clk);
      rstn = 1'b0;
      #1;
      check("reset_mid_search", {note, octave, valid, changed}, {4'hF, 4'h0, 1'b0, 1'b0});
      repeat (5) @(negedge clk);
      tone_in = 1'b0;
      rstn    = 1'b1;
      repeat (1200) @(negedge clk);
      check("post_reset_idle", {note, octave, valid}, {4'hF, 4'h0, 1'b0});
      run_tone(1775, 3);
      check("post_reset_pending", valid, 1'b0);
      run_tone(1775, 1);
      check_out("post_reset_lock", 4'd9, 4'd6, 1'b1, 6);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
